// File: rtl/aes_pkg.sv
// Shared AES definitions: result geometry and the output-side state encoding.
package aes_pkg;

  // Width of the AES result bus presented by the AES top.
  localparam int MSG_OUT_W = 136;

  // One serialized output byte.
  localparam int BYTE_W = 8;

  // Bytes per AES result.
  localparam int NUM_BYTES = 17;

  // Byte index width; wide enough for NUM_BYTES-1.
  localparam int IDX_W = 5;

  // Serializer states: waiting for a result, or streaming one out.
  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/aes_output_serializer.sv
// Captures an AES result on the rising edge of done and streams it out
// MSB-first as NUM_BYTES bytes over a valid/ready byte interface. A result
// arriving while one is still in flight is dropped and flagged as overrun,
// except when it lands exactly on the final transfer, where it is chained in
// back-to-back.
module aes_output_serializer #(
  parameter int BYTE_W    = aes_pkg::BYTE_W,
  parameter int NUM_BYTES = aes_pkg::NUM_BYTES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          done,
  input  logic [0:NUM_BYTES*BYTE_W-1]   messageOut,
  input  logic                          clearOverrun,
  input  logic                          byteReady,
  output logic [BYTE_W-1:0]             byteOut,
  output logic                          byteValid,
  output logic                          lastByte,
  output logic                          busy,
  output logic                          overrun
);

  localparam int MSG_W = NUM_BYTES * BYTE_W;
  localparam int IDX_W = aes_pkg::IDX_W;
  localparam int SEL_W = $clog2(MSG_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  aes_pkg::state_t stateReg;
  aes_pkg::state_t stateNext;
  logic [IDX_W-1:0]  idxReg;
  logic [IDX_W-1:0]  idxNext;
  logic [BYTE_W-1:0] byteReg;
  logic [BYTE_W-1:0] byteNext;
  logic              overrunReg;
  logic              overrunNext;
  logic              doneQ;
  logic              loadHold;
  logic [0:MSG_W-1]  holdReg;

  logic capture;
  logic sending;
  logic transfer;
  logic atLast;

  // Byte idx of a result; bit 0 of the result is the MSB of byte 0.
  function automatic logic [BYTE_W-1:0] pickByte(
    input logic [0:MSG_W-1] msg,
    input logic [IDX_W-1:0] idx
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(idx) * SEL_W'(BYTE_W);
    return msg[sel +: BYTE_W];
  endfunction

  // A held-high done only produces one capture: look for its rising edge.
  assign capture  = done & ~doneQ;
  assign sending  = (stateReg == aes_pkg::SEND);
  assign transfer = sending & byteReady;
  assign atLast   = (idxReg == LAST_IDX);

  assign byteValid = sending;
  assign busy      = sending;
  assign lastByte  = sending & atLast;
  assign byteOut   = byteReg;
  assign overrun   = overrunReg;

  // done delay register; it follows done even through reset so that a level
  // already high when reset releases is not mistaken for a new result.
  always_ff @(posedge clock) begin
    doneQ <= done;
  end

  // Next-state, next-byte and overrun decisions.
  always_comb begin
    stateNext   = stateReg;
    idxNext     = idxReg;
    byteNext    = byteReg;
    overrunNext = overrunReg;
    loadHold    = 1'b0;

    // Clear first so that an overrun event in the same cycle overrides it.
    if (clearOverrun) begin
      overrunNext = 1'b0;
    end

    case (stateReg)
      aes_pkg::IDLE: begin
        if (capture) begin
          stateNext = aes_pkg::SEND;
          idxNext   = '0;
          byteNext  = pickByte(messageOut, '0);
          loadHold  = 1'b1;
        end
      end

      aes_pkg::SEND: begin
        if (transfer && atLast) begin
          if (capture) begin
            // Chain the new result straight in: no idle gap, no overrun.
            idxNext  = '0;
            byteNext = pickByte(messageOut, '0);
            loadHold = 1'b1;
          end else begin
            stateNext = aes_pkg::IDLE;
          end
        end else begin
          if (transfer) begin
            idxNext  = idxReg + 1'b1;
            byteNext = pickByte(holdReg, idxReg + 1'b1);
          end
          // A result arriving mid-stream cannot be buffered: drop and flag it.
          if (capture) begin
            overrunNext = 1'b1;
          end
        end
      end

      default: begin
        stateNext = aes_pkg::IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg   <= aes_pkg::IDLE;
      idxReg     <= '0;
      byteReg    <= '0;
      overrunReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      idxReg     <= idxNext;
      byteReg    <= byteNext;
      overrunReg <= overrunNext;
    end
  end

  // Result holding register; contents are only meaningful while sending.
  always_ff @(posedge clock) begin
    if (loadHold) begin
      holdReg <= messageOut;
    end
  end

endmodule

// File: tb/tb_aes_output_serializer.sv
// Scoreboard bench for aes_output_serializer: directed AES results, expected
// bytes queued at stimulus time, checked by an independent output monitor.
module tb_aes_output_serializer;

  localparam int NB = 17;

  logic         clock        = 1'b0;
  logic         reset        = 1'b1;
  logic         done         = 1'b0;
  logic [0:135] messageOut   = '0;
  logic         clearOverrun = 1'b0;
  logic         byteReady    = 1'b0;
  logic [7:0]   byteOut;
  logic         byteValid;
  logic         lastByte;
  logic         busy;
  logic         overrun;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  logic [0:135] msgA = 136'h00_00112233445566778899AABBCCDDEEFF;
  logic [0:135] msgB = 136'hA5_0102030405060708090A0B0C0D0E0F10;

  logic [7:0] bytesA [NB] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA,
                              8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
  logic [7:0] bytesB [NB] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                              8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B,
                              8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};

  aes_output_serializer dut (
    .clock        (clock),
    .reset        (reset),
    .done         (done),
    .messageOut   (messageOut),
    .clearOverrun (clearOverrun),
    .byteReady    (byteReady),
    .byteOut      (byteOut),
    .byteValid    (byteValid),
    .lastByte     (lastByte),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushMsg(input bit useB);
    for (int i = 0; i < NB; i++) begin
      sb.push_back({useB ? bytesB[i] : bytesA[i], (i == NB - 1)});
    end
  endtask

  task automatic pulseDone(input logic [0:135] msg);
    messageOut = msg;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int n = 0; n < 100 && busy; n++) begin
      tick();
    end
    check(name, busy, 0);
  endtask

  // Output monitor: pops the scoreboard on every accepted byte and checks
  // that a stalled byte is held unchanged.
  logic [7:0] stallByte = '0;
  logic       stalled   = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && byteValid) begin
        check("stall_hold", byteOut, stallByte);
      end
      if (byteValid && byteReady) begin
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("FAIL unexpected_byte: got byte %h, required no byte", byteOut);
        end else begin
          popped = sb.pop_front();
          $display("tb: transfer byte=%h last=%b (expected %h last=%b)",
                   byteOut, lastByte, popped.data, popped.last);
          check("byte_data", byteOut, popped.data);
          check("byte_last", lastByte, popped.last);
        end
      end
      stalled   = byteValid && !byteReady;
      stallByte = byteOut;
    end
  end

  // Hard stop in case the design never settles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", byteValid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", lastByte, 0);
    check("rst_overrun", overrun, 0);
    check("rst_byte", byteOut, 8'h00);
    reset = 1'b0;
    tick();

    // T1: full-rate transfer.
    byteReady = 1'b1;
    pushMsg(1'b0);
    pulseDone(msgA);
    check("t1_latency", byteValid, 1);
    check("t1_busy", busy, 1);
    repeat (16) tick();
    check("t1_last_pending", lastByte, 1);
    check("t1_last_byte", byteOut, 8'hFF);
    tick();
    check("t1_busy_fall", busy, 0);
    check("t1_valid_fall", byteValid, 0);
    check("t1_last_fall", lastByte, 0);
    check("t1_idle_hold", byteOut, 8'hFF);
    check("t1_drained", sb.size(), 0);

    // T2: downstream toggling ready every cycle.
    pushMsg(1'b0);
    pulseDone(msgA);
    check("t2_latency", byteValid, 1);
    for (int c = 0; c < 80 && busy; c++) begin
      byteReady = ~byteReady;
      tick();
    end
    byteReady = 1'b1;
    check("t2_busy", busy, 0);
    check("t2_drained", sb.size(), 0);

    // T3: second result while byte 5 is pending.
    pushMsg(1'b0);
    pulseDone(msgA);
    repeat (5) tick();
    check("t3_byte5", byteOut, 8'h44);
    check("t3_no_overrun_yet", overrun, 0);
    pulseDone(msgB);
    check("t3_overrun", overrun, 1);
    waitIdle("t3_idle");
    check("t3_drained", sb.size(), 0);
    repeat (5) tick();
    check("t3_no_second", busy, 0);
    check("t3_overrun_sticky", overrun, 1);
    clearOverrun = 1'b1;
    tick();
    clearOverrun = 1'b0;
    check("t3_overrun_clear", overrun, 0);

    // T4: new result coincident with the final transfer.
    pushMsg(1'b0);
    pulseDone(msgA);
    repeat (16) tick();
    check("t4_last_pending", lastByte, 1);
    pushMsg(1'b1);
    pulseDone(msgB);
    check("t4_valid", byteValid, 1);
    check("t4_first_byte", byteOut, 8'hA5);
    check("t4_overrun", overrun, 0);
    check("t4_last_low", lastByte, 0);
    waitIdle("t4_idle");
    check("t4_drained", sb.size(), 0);

    // T5: overrun with simultaneous clear (set wins), then reset after byte 8.
    pushMsg(1'b0);
    pulseDone(msgA);
    repeat (2) tick();
    clearOverrun = 1'b1;
    pulseDone(msgB);
    clearOverrun = 1'b0;
    check("t5_set_wins", overrun, 1);
    repeat (6) tick();
    check("t5_byte9", byteOut, 8'h88);
    reset = 1'b1;
    sb.delete();
    tick();
    check("t5_rst_valid", byteValid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_last", lastByte, 0);
    check("t5_rst_byte", byteOut, 8'h00);
    reset = 1'b0;
    tick();
    pushMsg(1'b1);
    pulseDone(msgB);
    check("t5_restart_valid", byteValid, 1);
    check("t5_restart_byte", byteOut, 8'hA5);
    waitIdle("t5_idle");
    check("t5_drained", sb.size(), 0);

    // T6: done held high for 40 cycles, then reset with done still high.
    pushMsg(1'b1);
    messageOut = msgB;
    done = 1'b1;
    tick();
    check("t6_valid", byteValid, 1);
    repeat (39) tick();
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    check("t6_drained", sb.size(), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t6_no_capture_after_rst", busy, 0);
    done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
